// File: rtl/serializer_pkg.sv
// Shared definitions for the multilane serializer.
// Holds FSM state encodings and the beat-count/counter-width helpers.
package serializer_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    function automatic int beats_f(input int dw, input int lw);
        return dw / lw;
    endfunction

    // Counter must hold 0..BEATS-1; never narrower than one bit.
    function automatic int cnt_w_f(input int dw, input int lw);
        return (dw / lw > 1) ? $clog2(dw / lw) : 1;
    endfunction

endpackage

// File: rtl/word_stage.sv
// One-word staging register with full flag in front of the shifter.
// Ports: i_clk/i_rst/i_en control, iv_din/i_din_valid/o_din_ready
// upstream handshake, i_take empties it, o_full/ov_word to the shifter.
module word_stage #(
    parameter int DATA_W = 24
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [DATA_W-1:0] iv_din,
    input  logic              i_din_valid,
    input  logic              i_take,
    output logic              o_din_ready,
    output logic              o_full,
    output logic [DATA_W-1:0] ov_word
);

    logic              full_q, full_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              accept;

    assign o_din_ready = i_en & ~full_q;
    assign accept      = o_din_ready & i_din_valid;

    // Accept and take are exclusive: one needs empty, the other full.
    always_comb begin
        full_d = full_q;
        word_d = word_q;
        if (accept) begin
            full_d = 1'b1;
            word_d = iv_din;
        end else if (i_take) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            full_q <= 1'b0;
            word_q <= '0;
        end else if (i_en) begin
            full_q <= full_d;
            word_q <= word_d;
        end
    end

    assign o_full  = full_q;
    assign ov_word = word_q;

endmodule

// File: rtl/multilane_serializer.sv
// Parallel-to-serial converter emitting LANE_W bits per beat.
// Ports: i_clk/i_rst/i_en control, iv_din/i_din_valid/o_din_ready input,
// ov_dout/o_dout_valid/i_dout_ready/o_last output beats, o_busy status.
module multilane_serializer
    import serializer_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int LANE_W    = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [DATA_W-1:0] iv_din,
    input  logic              i_din_valid,
    output logic              o_din_ready,
    output logic [LANE_W-1:0] ov_dout,
    output logic              o_dout_valid,
    input  logic              i_dout_ready,
    output logic              o_last,
    output logic              o_busy
);

    localparam int BEATS = beats_f(DATA_W, LANE_W);
    localparam int CNT_W = cnt_w_f(DATA_W, LANE_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    if ((DATA_W % LANE_W) != 0 || (DATA_W / LANE_W) < 2) begin : g_bad_param
        $error("multilane_serializer: DATA_W must be a multiple of LANE_W with >= 2 beats");
    end

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] sh_next;
    logic [LANE_W-1:0] lane;

    logic              stg_full;
    logic [DATA_W-1:0] stg_word;
    logic              shifting;
    logic              last;
    logic              beat;
    logic              load;

    word_stage #(
        .DATA_W (DATA_W)
    ) u_stage (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .iv_din      (iv_din),
        .i_din_valid (i_din_valid),
        .i_take      (load),
        .o_din_ready (o_din_ready),
        .o_full      (stg_full),
        .ov_word     (stg_word)
    );

    // The output lane always sits at the end the register shifts toward.
    if (MSB_FIRST) begin : g_msb
        assign lane    = sh_q[DATA_W-1 -: LANE_W];
        assign sh_next = sh_q << LANE_W;
    end else begin : g_lsb
        assign lane    = sh_q[LANE_W-1:0];
        assign sh_next = sh_q >> LANE_W;
    end

    assign shifting = (state_q == ST_SHIFT);
    assign last     = shifting & (cnt_q == LAST_CNT);
    assign beat     = i_en & shifting & i_dout_ready;
    // Reload on the final accepted beat keeps back-to-back words gapless.
    assign load     = i_en & stg_full & (~shifting | (beat & last));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        if (load) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
            sh_d    = stg_word;
        end else if (beat) begin
            sh_d = sh_next;
            if (last) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else if (i_en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

    assign o_dout_valid = i_en & shifting;
    assign ov_dout      = o_dout_valid ? lane : '0;
    assign o_last       = last;
    assign o_busy       = stg_full | shifting;

endmodule

// File: doc/multilane_serializer.md
MULTILANE_SERIALIZER -- requirements
Module: multilane_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 24: parallel word width in bits.
REQ-002 SHALL have parameter LANE_W, default 1: bits emitted per output beat; DATA_W % LANE_W == 0 and DATA_W/LANE_W >= 2 (elaboration error otherwise).
REQ-003 SHALL have parameter MSB_FIRST, default 0: 0 = least-significant lane first, 1 = most-significant lane first.
REQ-004 SHALL have port i_clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port i_en  input  1  clock enable; low freezes all state.
REQ-007 SHALL have port iv_din  input  DATA_W  parallel input word.
REQ-008 SHALL have port i_din_valid  input  1  input word valid.
REQ-009 SHALL have port o_din_ready  output  1  staging register can accept a word.
REQ-010 SHALL have port ov_dout  output  LANE_W  current output lane.
REQ-011 SHALL have port o_dout_valid  output  1  ov_dout valid.
REQ-012 SHALL have port i_dout_ready  input  1  downstream accepts beat.
REQ-013 SHALL have port o_last  output  1  current beat is the final lane of its word.
REQ-014 SHALL have port o_busy  output  1  staging full or shifter active.

Function
REQ-015 Transfers: input when i_en & i_din_valid & o_din_ready; output beat when i_en & o_dout_valid & i_dout_ready (valid/ready, no combinational ready-to-valid path).
REQ-016 o_din_ready = i_en & staging empty; o_dout_valid = i_en & state==SHIFT; both low while i_en low.
REQ-017 Input word lands in staging register on the accepting edge; valid must not depend on ready (upstream may hold valid).
REQ-018 FSM states IDLE, SHIFT; IDLE->SHIFT when staging full (shifter loads staging, staging empties, beat counter = 0).
REQ-019 In SHIFT, each accepted beat advances counter (width $clog2(BEATS), BEATS = DATA_W/LANE_W) and shifts the register by LANE_W toward the output end; no advance without i_dout_ready (data and o_last held stable).
REQ-020 o_last = SHIFT & counter == BEATS-1.
REQ-021 On the accepted last beat: staging full -> reload shifter from staging, stay SHIFT, next beat the following cycle (no bubble); staging empty -> IDLE.
REQ-022 Simultaneous last-beat acceptance and input acceptance cannot occur (ready needs staging empty); word accepted in the cycle staging empties is shifted back-to-back.
REQ-023 Latency: word accepted at edge N -> first beat valid after edge N+1; sustained throughput one word per BEATS cycles with i_dout_ready held high.
REQ-024 MSB_FIRST=0: beat k = iv_din[k*LANE_W +: LANE_W]; MSB_FIRST=1: beat k = iv_din[DATA_W-1-k*LANE_W -: LANE_W].
REQ-025 ov_dout SHALL be 0 whenever o_dout_valid is low.
REQ-026 o_busy = staging full | state==SHIFT.

Reset
REQ-027 i_rst (synchronous, overrides i_en) SHALL force IDLE, staging empty, shift register 0, counter 0; all outputs 0 the cycle after.
REQ-028 Reset mid-word SHALL discard the shifting and staged words; no further beats emitted.

Structure
REQ-029 State encodings and a BEATS/counter-width helper SHALL live in shared package serializer_pkg.
REQ-030 Staging register with its full flag SHALL be sub-module word_stage; FSM, counter and shifter stay in the top.

Verification
REQ-031 DATA_W=24, LANE_W=1, MSB_FIRST=0, din=24'hA5C3F0, dout_ready=1 -> 24 beats 0,0,0,0,1,1,1,1,1,1,0,0,..., o_last on beat 24 only.
REQ-032 DATA_W=24, LANE_W=4, MSB_FIRST=1, din=24'h123456 -> beats 1,2,3,4,5,6; then IDLE, o_busy 0.
REQ-033 Two words 24'h000001, 24'h800000 back-to-back, LANE_W=1 -> 48 consecutive valid beats, no gap; second word accepted only after first loads.
REQ-034 LANE_W=8, din=24'hAABBCC, dout_ready toggled 1,0,0,1,1 -> beats CC,BB,AA; ov_dout/o_last stable while ready low.
REQ-035 i_en low 3 cycles mid-word -> no transfers, valid/ready low, resume at the same beat.
REQ-036 i_rst asserted at beat 10 of 24 with staged word -> next cycle all outputs 0, o_din_ready 1 after reset released.
